ascii_digit_sequencer: RTL and testbench
========================================

Name: ascii_digit_sequencer

Overview:
- Playback controller for the single-digit ASCII-to-7-segment common-cathode driver.
- Holds a short ASCII message loaded through a valid/ready write port.
- On start, presents the characters one at a time to the decoder's ASCII input, with a fixed dwell time per character and a blank gap between characters.
- Supports one-shot and looping playback plus abort.

Parameters:
DEPTH, 16, message buffer entries; must be a power of 2 and at least 2
DWELL_CYC, 25_000_000, clock cycles each character is shown (at least 1; 0.5 s at 50 MHz)
GAP_CYC, 5_000_000, clock cycles of blank between characters; 0 means no gap

Ports:
clk50MHz  in  1  system clock, 50 MHz
rst  in  1  asynchronous reset, active-high
wr_valid  in  1  write request for one character
wr_char  in  8  ASCII character to append
wr_ready  out  1  combinational: !busy && !full && !clear
clear  in  1  empty the buffer (len=0); acted on only when idle
start  in  1  begin playback at index 0; ignored if busy or len=0
stop  in  1  abort playback
loop  in  1  1 = restart at index 0 after the last character's gap
busy  out  1  playback active
done  out  1  one-cycle pulse when one-shot playback completes
ascii_out  out  8  character for the decoder
dp_out  out  1  decimal point for the decoder
len  out  log2(DEPTH)+1  characters stored

Behaviour:
Reset (async, rst=1):
- State=IDLE, len=0, idx=0, timer=0.
- busy=0, done=0, ascii_out=8'h20, dp_out=0.
- Buffer contents are don't-care.

Write port:
- Write accepted at an edge where wr_valid && wr_ready: buf[len] <= wr_char, len <= len+1.
- full = (len==DEPTH).
- clear has priority over a same-cycle write; the write is dropped (wr_ready is already 0).
- clear while busy is ignored.
- A write and start in the same idle cycle are both accepted. Playback starts at index 0; the new character is included (len updates on the same edge).

FSM states: IDLE, SHOW, GAP, DONE.
- IDLE:
  - start && len>0 -> SHOW, idx=0, timer=0.
  - Registered outputs, so busy=1 and ascii_out=buf[0] from the next edge (1-cycle latency).
- SHOW:
  - ascii_out=buf[idx], dp_out per Optional Feature (else 0).
  - After exactly DWELL_CYC cycles: go to GAP if GAP_CYC>0, else go straight to the advance step.
- GAP:
  - ascii_out=8'h20, dp_out=0, for exactly GAP_CYC cycles, then advance.
- Advance step:
  - next = idx+step, with step=1 (or 2 when merged).
  - If next<len: -> SHOW at next.
  - Else if loop=1 (sampled at that edge): -> SHOW at idx=0.
  - Else -> DONE.
- DONE:
  - done=1 for one cycle, busy=0, ascii_out=8'h20, then -> IDLE.
  - Buffer is retained, so start replays the same message.

Boundary and priority rules:
- stop in SHOW/GAP: next edge -> IDLE, busy=0, ascii_out=8'h20, dp_out=0, no done pulse.
- stop has priority over the advance step and over loop.
- start while busy is ignored.
- len=1 with loop=1: the single character repeats, with the gap between repeats.
- idx wraps only via the loop rule, never by overflow.
- Mid-operation rst: immediate return to reset values; the message is lost (len=0).

Optional Feature:
Macro: ASCII_SEQ_DOT_MERGE_EN
- Defined:
  - In SHOW, if buf[idx] != 8'h2E, idx+1 < len and buf[idx+1] == 8'h2E: dp_out=1 and step=2, so the dot is consumed with no separate slot.
  - A '.' not merged (leading, or following another '.') shows ascii_out=8'h20 with dp_out=1.
- Not defined:
  - '.' is passed through as 8'h2E with dp_out=0.
  - dp_out is constant 0; step is always 1.

Test Plan (DWELL_CYC=4, GAP_CYC=2, DEPTH=4):
1. Reset, write "A","B" then start, loop=0 -> busy=1 one cycle after start. ascii_out is 8'h41 for 4 cycles, 8'h20 for 2, 8'h42 for 4, 8'h20 for 2. Then done pulses once, busy=0, len stays 2.
2. Write 5 characters back-to-back with wr_valid held -> 4 accepted. wr_ready=0 after the 4th; len=4.
3. Load "12" with loop=1, start -> sequence 31,20,32,20,31,... repeats. Assert stop during the 2nd '2' -> IDLE next edge, ascii_out=8'h20, no done pulse.
4. During playback: assert clear and wr_valid, and pulse start -> no write, len unchanged, playback timing unaffected. After done, clear -> len=0; start with len=0 ignored.
5. Load "3",".","4" with the macro defined -> 8'h33 with dp_out=1 for 4 cycles, gap, 8'h34 with dp=0, done. Without the macro -> 33,2E,34 shown, dp_out always 0.
6. GAP_CYC=0, "XY" -> 8'h58 for 4 cycles directly followed by 8'h59 for 4 cycles. Assert rst mid-character -> outputs return to reset values immediately.

Source files
------------

// File: rtl/ascii_digit_sequencer.sv
// Playback controller feeding a single-digit ASCII-to-7-segment decoder from a small message buffer.
// Optional dot merging (dp on the preceding character) is enabled by defining ASCII_SEQ_DOT_MERGE_EN.
module ascii_digit_sequencer #(
  parameter int DEPTH     = 16,
  parameter int DWELL_CYC = 25_000_000,
  parameter int GAP_CYC   = 5_000_000
) (
  input  logic                     clk50MHz,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_char,
  output logic                     wr_ready,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               ascii_out,
  output logic                     dp_out,
  output logic [$clog2(DEPTH):0]   len
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0]  CH_SPACE   = 8'h20;
  localparam logic [7:0]  CH_DOT     = 8'h2E;
  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYC - 1);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [31:0]   timer_q, timer_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    ascii_q, ascii_d;
  logic          dp_q, dp_d;
  logic [7:0]    buf_q [DEPTH];
  logic [7:0]    view_s [DEPTH];

  logic          full_s;
  logic          wr_fire_s;
  logic          clear_fire_s;
  logic [LW-1:0] len_eff_s;
  logic [LW-1:0] step_s;
  logic [LW-1:0] next_idx_s;
  state_t        adv_state_s;
  logic [LW-1:0] adv_idx_s;
  logic [7:0]    show_char_s;

  assign full_s       = (len_q == LW'(DEPTH));
  assign wr_ready     = !busy_q && !full_s && !clear;
  assign wr_fire_s    = wr_valid && wr_ready;
  assign clear_fire_s = clear && !busy_q;
  assign len_eff_s    = len_q + LW'(wr_fire_s);

  assign busy      = busy_q;
  assign done      = done_q;
  assign ascii_out = ascii_q;
  assign dp_out    = dp_q;
  assign len       = len_q;

  // Buffer as seen after this edge's write, so a write coinciding with start is shown at once.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      view_s[i] = (wr_fire_s && (len_q[AW-1:0] == AW'(i))) ? wr_char : buf_q[i];
    end
  end

`ifdef ASCII_SEQ_DOT_MERGE_EN
  logic merge_cur_s;
  logic merge_nxt_s;

  assign merge_cur_s = (buf_q[idx_q[AW-1:0]] != CH_DOT) &&
                       ((idx_q + LW'(1)) < len_q) &&
                       (buf_q[idx_q[AW-1:0] + AW'(1)] == CH_DOT);
  assign merge_nxt_s = (view_s[idx_d[AW-1:0]] != CH_DOT) &&
                       ((idx_d + LW'(1)) < len_d) &&
                       (view_s[idx_d[AW-1:0] + AW'(1)] == CH_DOT);
  assign step_s      = merge_cur_s ? LW'(2) : LW'(1);
`else
  assign step_s      = LW'(1);
`endif

  assign next_idx_s  = idx_q + step_s;
  assign show_char_s = view_s[idx_d[AW-1:0]];

  // Advance step: next character, wrap on loop, or finish.
  always_comb begin
    if (next_idx_s < len_q) begin
      adv_state_s = S_SHOW;
      adv_idx_s   = next_idx_s;
    end else if (loop) begin
      adv_state_s = S_SHOW;
      adv_idx_s   = LW'(0);
    end else begin
      adv_state_s = S_DONE;
      adv_idx_s   = LW'(0);
    end
  end

  // Next-state logic; stop outranks the advance step.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    len_d   = clear_fire_s ? LW'(0) : len_eff_s;
    case (state_q)
      S_IDLE: begin
        if (start && !clear && (len_eff_s != LW'(0))) begin
          state_d = S_SHOW;
          idx_d   = LW'(0);
          timer_d = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHOW: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = LW'(0);
          timer_d = 32'd0;
        end else if (timer_q == DWELL_LAST) begin
          timer_d = 32'd0;
          if (GAP_CYC > 0) begin
            state_d = S_GAP;
          end else begin
            state_d = adv_state_s;
            idx_d   = adv_idx_s;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = LW'(0);
          timer_d = 32'd0;
        end else if (timer_q == GAP_LAST) begin
          timer_d = 32'd0;
          state_d = adv_state_s;
          idx_d   = adv_idx_s;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = LW'(0);
        timer_d = 32'd0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = LW'(0);
        timer_d = 32'd0;
      end
    endcase
  end

  // Output values for the state being entered, so the registered outputs align with it.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ascii_d = CH_SPACE;
    dp_d    = 1'b0;
    case (state_d)
      S_SHOW: begin
        busy_d = 1'b1;
`ifdef ASCII_SEQ_DOT_MERGE_EN
        if (show_char_s == CH_DOT) begin
          ascii_d = CH_SPACE;
          dp_d    = 1'b1;
        end else begin
          ascii_d = show_char_s;
          dp_d    = merge_nxt_s;
        end
`else
        ascii_d = show_char_s;
`endif
      end
      S_GAP:   busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      S_IDLE:  busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= LW'(0);
      idx_q   <= LW'(0);
      timer_q <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ascii_q <= CH_SPACE;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ascii_q <= ascii_d;
      dp_q    <= dp_d;
    end
  end

  // Message storage; contents need no reset.
  always_ff @(posedge clk50MHz) begin
    if (wr_fire_s) begin
      buf_q[len_q[AW-1:0]] <= wr_char;
    end
  end

endmodule

// File: tb/tb_ascii_digit_sequencer.sv
// Directed bench for ascii_digit_sequencer: DEPTH=4, DWELL_CYC=4, GAP_CYC=2 plus a GAP_CYC=0 instance.
module tb_ascii_digit_sequencer;

  logic       clk = 1'b0;
  logic       rst, wr_valid, clear, start, stop, loop;
  logic [7:0] wr_char;
  logic       wr_ready, busy, done, dp;
  logic [7:0] ascii;
  logic [2:0] len;
  logic       wr_ready0, busy0, done0, dp0;
  logic [7:0] ascii0;
  logic [2:0] len0;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       wv;
    logic [7:0] wc;
    logic       st;
    logic       e_busy;
    logic       e_done;
    logic [7:0] e_ascii;
    logic [2:0] e_len;
  } vec_t;

  vec_t       tbl [16];
  logic [7:0] ea [$];
  logic       ep [$];

  ascii_digit_sequencer #(.DEPTH(4), .DWELL_CYC(4), .GAP_CYC(2)) u_dut (
    .clk50MHz(clk), .rst(rst), .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready),
    .clear(clear), .start(start), .stop(stop), .loop(loop), .busy(busy), .done(done),
    .ascii_out(ascii), .dp_out(dp), .len(len)
  );

  ascii_digit_sequencer #(.DEPTH(4), .DWELL_CYC(4), .GAP_CYC(0)) u_dut0 (
    .clk50MHz(clk), .rst(rst), .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready0),
    .clear(clear), .start(start), .stop(stop), .loop(loop), .busy(busy0), .done(done0),
    .ascii_out(ascii0), .dp_out(dp0), .len(len0)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic row(input int i, input logic wv, input logic [7:0] wc, input logic st,
                     input logic eb, input logic ed, input logic [7:0] ea_v, input logic [2:0] el);
    tbl[i] = '{wv, wc, st, eb, ed, ea_v, el};
  endtask

  task automatic add(input logic [7:0] a, input logic p, input int n);
    repeat (n) begin
      ea.push_back(a);
      ep.push_back(p);
    end
  endtask

  task automatic write_char(input logic [7:0] c);
    wr_valid = 1'b1;
    wr_char  = c;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Sample 0 is taken right after the start edge; dist_at injects clear/write/start while busy.
  task automatic run_seq(input string name, input int dist_at, input bit exp_done, input logic [2:0] exp_len);
    for (int c = 0; c < ea.size(); c++) begin
      if (c > 0) begin
        if (c == dist_at) begin
          clear = 1'b1; wr_valid = 1'b1; wr_char = 8'h5A; start = 1'b1;
          chk($sformatf("%s c%0d wr_ready", name, c), 32'(wr_ready), 32'd0);
        end
        if (c == dist_at + 2) begin
          clear = 1'b0; wr_valid = 1'b0; start = 1'b0;
        end
        step();
      end
      chk($sformatf("%s c%0d ascii", name, c), 32'(ascii), 32'(ea[c]));
      chk($sformatf("%s c%0d dp", name, c), 32'(dp), 32'(ep[c]));
      chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'd1);
      chk($sformatf("%s c%0d len", name, c), 32'(len), 32'(exp_len));
    end
    if (exp_done) begin
      step();
      chk({name, " done pulse"}, 32'(done), 32'd1);
      chk({name, " done busy"}, 32'(busy), 32'd0);
      chk({name, " done ascii"}, 32'(ascii), 32'h20);
      step();
      chk({name, " done clears"}, 32'(done), 32'd0);
    end
    ea.delete();
    ep.delete();
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_char = 8'h00; clear = 1'b0;
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset ascii", 32'(ascii), 32'h20);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset dp", 32'(dp), 32'd0);
    chk("reset len", 32'(len), 32'd0);
    chk("reset wr_ready", 32'(wr_ready), 32'd1);
    chk("reset ascii g0", 32'(ascii0), 32'h20);

    // Test 1: "AB" one-shot, cycle by cycle.
    row(0,  1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h20, 3'd1);
    row(1,  1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h20, 3'd2);
    row(2,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h41, 3'd2);
    for (int i = 3; i <= 5; i++)   row(i, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 3'd2);
    for (int i = 6; i <= 7; i++)   row(i, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h20, 3'd2);
    for (int i = 8; i <= 11; i++)  row(i, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h42, 3'd2);
    for (int i = 12; i <= 13; i++) row(i, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h20, 3'd2);
    row(14, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h20, 3'd2);
    row(15, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 3'd2);
    for (int i = 0; i < 16; i++) begin
      wr_valid = tbl[i].wv;
      wr_char  = tbl[i].wc;
      start    = tbl[i].st;
      step();
      chk($sformatf("t1 row%0d ascii", i), 32'(ascii), 32'(tbl[i].e_ascii));
      chk($sformatf("t1 row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("t1 row%0d done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("t1 row%0d len", i), 32'(len), 32'(tbl[i].e_len));
      chk($sformatf("t1 row%0d dp", i), 32'(dp), 32'd0);
    end
    wr_valid = 1'b0;
    start    = 1'b0;

    // Test 2: five back-to-back writes into a 4-entry buffer.
    do_reset();
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_char = 8'h61 + 8'(i);
      chk($sformatf("t2 wr_ready w%0d", i), 32'(wr_ready), (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    chk("t2 len full", 32'(len), 32'd4);
    chk("t2 wr_ready full", 32'(wr_ready), 32'd0);
    wr_valid = 1'b0;
    clear = 1'b1;
    chk("t2 wr_ready clear", 32'(wr_ready), 32'd0);
    step();
    clear = 1'b0;
    chk("t2 len cleared", 32'(len), 32'd0);

    // Test 3: looping "12", stop during the second '2'.
    write_char(8'h31);
    write_char(8'h32);
    loop = 1'b1;
    do_start();
    add(8'h31, 1'b0, 4); add(8'h20, 1'b0, 2); add(8'h32, 1'b0, 4); add(8'h20, 1'b0, 2);
    add(8'h31, 1'b0, 4); add(8'h20, 1'b0, 2); add(8'h32, 1'b0, 2);
    run_seq("t3", -1, 1'b0, 3'd2);
    loop = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t3 stop busy", 32'(busy), 32'd0);
    chk("t3 stop ascii", 32'(ascii), 32'h20);
    chk("t3 stop dp", 32'(dp), 32'd0);
    chk("t3 stop no done", 32'(done), 32'd0);
    step();
    chk("t3 stop no done later", 32'(done), 32'd0);
    chk("t3 stop stays idle", 32'(busy), 32'd0);

    // Test 4: clear/write/start while busy are ignored; then clear and start on empty buffer.
    do_start();
    add(8'h31, 1'b0, 4); add(8'h20, 1'b0, 2); add(8'h32, 1'b0, 4); add(8'h20, 1'b0, 2);
    run_seq("t4", 2, 1'b1, 3'd2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t4 len after clear", 32'(len), 32'd0);
    do_start();
    chk("t4 empty start busy", 32'(busy), 32'd0);
    step();
    chk("t4 empty start busy later", 32'(busy), 32'd0);
    chk("t4 empty start ascii", 32'(ascii), 32'h20);

    // Test 5: "3.4" with or without dot merging.
    write_char(8'h33);
    write_char(8'h2E);
    write_char(8'h34);
    do_start();
`ifdef ASCII_SEQ_DOT_MERGE_EN
    add(8'h33, 1'b1, 4); add(8'h20, 1'b0, 2); add(8'h34, 1'b0, 4); add(8'h20, 1'b0, 2);
`else
    add(8'h33, 1'b0, 4); add(8'h20, 1'b0, 2); add(8'h2E, 1'b0, 4); add(8'h20, 1'b0, 2);
    add(8'h34, 1'b0, 4); add(8'h20, 1'b0, 2);
`endif
    run_seq("t5", -1, 1'b1, 3'd3);

    // Test 6: zero gap, then asynchronous reset mid-character.
    do_reset();
    write_char(8'h58);
    write_char(8'h59);
    do_start();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      chk($sformatf("t6 c%0d ascii", c), 32'(ascii0), (c < 4) ? 32'h58 : 32'h59);
      chk($sformatf("t6 c%0d busy", c), 32'(busy0), 32'd1);
    end
    #3 rst = 1'b1;
    #1;
    chk("t6 rst ascii", 32'(ascii0), 32'h20);
    chk("t6 rst busy", 32'(busy0), 32'd0);
    chk("t6 rst done", 32'(done0), 32'd0);
    chk("t6 rst dp", 32'(dp0), 32'd0);
    chk("t6 rst len", 32'(len0), 32'd0);
    chk("t6 rst len main", 32'(len), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("t6 after rst busy", 32'(busy0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
